psram_mem_arb: RTL and testbench

// - Round-robin arbiter that shares one single-port RAM access port between NREQ requesters
//   (DMA descriptor fetch, register/host path, debug readback, ...).
// - Sits between the requesters and the RAM. Uses the same req/ack word handshake as the
//   DMA cfg fetch: the requester holds req; each mem_ack completes one word.
// - Bounds burst tenure so a chained DMA fetch cannot starve other requesters.

---
 rtl/psram_pkg.sv | 22 ++
 rtl/psram_mem_arb_if.sv | 30 +++
 rtl/psram_rr_pick.sv | 32 +++
 rtl/psram_mem_arb.sv | 98 +++++++++
 tb/tb_psram_mem_arb.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM access path: arbiter state encoding and bus widths.
package psram_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_GRANT  = 2'd1;
    localparam logic [1:0] ARB_SWITCH = 2'd2;

    localparam int PSRAM_AW = 17;
    localparam int PSRAM_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = ARB_IDLE,
        ST_GRANT  = ARB_GRANT,
        ST_SWITCH = ARB_SWITCH
    } arb_state_e;

    // Width of an index into n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psram_mem_arb_if.sv
// Requester-side and RAM-side signals of the PSRAM arbiter, bundled as one bus.
interface psram_mem_arb_if #(
    parameter int NREQ = 4,
    parameter int AW   = 17,
    parameter int DW   = 32
) ();
    logic [NREQ-1:0]    rq_req;
    logic [NREQ-1:0]    rq_we;
    logic [NREQ*AW-1:0] rq_addr;
    logic [NREQ*DW-1:0] rq_wdata;
    logic [NREQ-1:0]    rq_ack;
    logic [DW-1:0]      rq_rdata;
    logic [NREQ-1:0]    rq_gnt;
    logic               mem_req;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_ack;
    logic [DW-1:0]      mem_rdata;

    modport slave (
        input  rq_req, rq_we, rq_addr, rq_wdata, mem_ack, mem_rdata,
        output rq_ack, rq_rdata, rq_gnt, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rq_req, rq_we, rq_addr, rq_wdata, mem_ack, mem_rdata,
        input  rq_ack, rq_rdata, rq_gnt, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/psram_rr_pick.sv
// Round-robin pick: first set request scanning upward from ptr_i with wrap.
module psram_rr_pick
    import psram_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    int j;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        j        = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!valid_o && req_i[j]) begin
                valid_o     = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/psram_mem_arb.sv
// Round-robin owner of the single RAM port with bounded burst tenure.
module psram_mem_arb
    import psram_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int AW        = PSRAM_AW,
    parameter int DW        = PSRAM_DW,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    psram_mem_arb_if.slave  bus
);

    localparam int         IW        = idx_w(NREQ);
    localparam logic [3:0] BCNT_MAX  = 4'(MAX_BURST);
    localparam logic [3:0] BCNT_LAST = 4'(MAX_BURST - 1);

    arb_state_e      state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   own_q;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   rr_d;
    logic [3:0]      bcnt_q;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    logic in_grant, owner_req, mem_req_c, ack_c, others_pending, burst_end;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.rq_addr[gi*AW +: AW];
        assign wdata_arr[gi] = bus.rq_wdata[gi*DW +: DW];
    end

    psram_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i    (bus.rq_req),
        .ptr_i    (rr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    assign in_grant       = (state_q == ST_GRANT);
    assign owner_req      = bus.rq_req[own_q];
    assign mem_req_c      = in_grant & owner_req;
    assign ack_c          = mem_req_c & bus.mem_ack;
    assign others_pending = |(bus.rq_req & ~gnt_q);
    // Preemption only on an ack cycle, so a word in flight is never cut off.
    assign burst_end      = ack_c && (bcnt_q == BCNT_LAST) && others_pending;
    assign rr_d           = (own_q == IW'(NREQ - 1)) ? '0 : own_q + IW'(1);

    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = in_grant & bus.rq_we[own_q];
    assign bus.mem_addr  = in_grant ? addr_arr[own_q]  : '0;
    assign bus.mem_wdata = in_grant ? wdata_arr[own_q] : '0;
    assign bus.rq_ack    = ack_c ? gnt_q : '0;
    assign bus.rq_rdata  = bus.mem_rdata;
    assign bus.rq_gnt    = gnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            rr_q    <= '0;
            bcnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= pick_onehot;
                        own_q   <= pick_idx;
                        bcnt_q  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (ack_c && (bcnt_q != BCNT_MAX)) begin
                        bcnt_q <= bcnt_q + 4'd1;
                    end
                    if (!owner_req || burst_end) begin
                        state_q <= ST_SWITCH;
                        gnt_q   <= '0;
                        rr_q    <= rr_d;
                    end
                end
                ST_SWITCH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_mem_arb.sv
// Directed vector table plus burst, reset and random-ack sequences for psram_mem_arb.
module tb_psram_mem_arb;
    import psram_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 17;
    localparam int DW   = 32;
    localparam int MB   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psram_mem_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    psram_mem_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [AW-1:0] addr_tb  [NREQ];
    logic [DW-1:0] wdata_tb [NREQ];

    always_comb begin
        bus.rq_addr  = '0;
        bus.rq_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.rq_addr[i*AW +: AW]  = addr_tb[i];
            bus.rq_wdata[i*DW +: DW] = wdata_tb[i];
        end
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  we;
        logic        ack;
        logic [31:0] rdata;
        logic        x_mreq;
        logic [3:0]  x_gnt;
        logic [3:0]  x_ack;
        logic        x_we;
        logic [16:0] x_addr;
        logic [31:0] x_wdata;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] w,
                                input logic a, input logic [31:0] rd, input logic xm,
                                input logic [3:0] xg, input logic [3:0] xa, input logic xw,
                                input logic [16:0] xad, input logic [31:0] xwd);
        vec_t v;
        v.rst = r; v.req = rq; v.we = w; v.ack = a; v.rdata = rd;
        v.x_mreq = xm; v.x_gnt = xg; v.x_ack = xa; v.x_we = xw;
        v.x_addr = xad; v.x_wdata = xwd;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rq_req = '0; bus.rq_we = '0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [16:0] A0 = 17'h0_0100, A1 = 17'h0_0201, A2 = 17'h1_0004, A3 = 17'h0_0403;
    localparam logic [31:0] W0 = 32'h1111_0000, W1 = 32'h2222_0001, W2 = 32'hDEAD_BEEF,
                            W3 = 32'h4444_0003;

    int words_left [NREQ];
    int order [$];
    int exp_order [11] = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 1, 1};
    logic ack_plan, prev_mreq, prev_ack;
    int done1, cyc, total_words, total_acks, owner;

    initial begin
        addr_tb  = '{A0, A1, A2, A3};
        wdata_tb = '{W0, W1, W2, W3};
        bus.mem_rdata = '0;
        rst = 1'b1;
        bus.rq_req = '0; bus.rq_we = '0; bus.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset mem_req",   64'(bus.mem_req),   64'h0);
        chk("reset rq_gnt",    64'(bus.rq_gnt),    64'h0);
        chk("reset rq_ack",    64'(bus.rq_ack),    64'h0);
        chk("reset mem_we",    64'(bus.mem_we),    64'h0);
        chk("reset mem_addr",  64'(bus.mem_addr),  64'h0);
        chk("reset mem_wdata", 64'(bus.mem_wdata), 64'h0);

        // single read, then two-requester rotation, owner drop, write, reset mid-tenure
        vt.push_back(mk(0, 4'h1, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h1, 0, 0, 0,             1, 4'h1, 4'h0, 0, A0, W0));
        vt.push_back(mk(0, 4'h1, 0, 0, 0,             1, 4'h1, 4'h0, 0, A0, W0));
        vt.push_back(mk(0, 4'h1, 0, 1, 32'hA5A5_0001, 1, 4'h1, 4'h1, 0, A0, W0));
        vt.push_back(mk(0, 4'h0, 0, 0, 0,             0, 4'h1, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h0, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(1, 4'h0, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h5, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h5, 0, 1, 32'h0000_1234, 1, 4'h1, 4'h1, 0, A0, W0));
        vt.push_back(mk(0, 4'h4, 0, 0, 0,             0, 4'h1, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h4, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h4, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h4, 0, 1, 32'h0000_5678, 1, 4'h4, 4'h4, 0, A2, W2));
        vt.push_back(mk(0, 4'h0, 0, 0, 0,             0, 4'h4, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h0, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h5, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h5, 0, 0, 0,             1, 4'h1, 4'h0, 0, A0, W0));
        vt.push_back(mk(0, 4'h4, 0, 0, 0,             0, 4'h1, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h4, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h4, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h6, 4'h4, 0, 0,          1, 4'h4, 4'h0, 1, A2, W2));
        vt.push_back(mk(0, 4'h6, 4'h4, 1, 32'h0000_9ABC, 1, 4'h4, 4'h4, 1, A2, W2));
        vt.push_back(mk(0, 4'h2, 0, 0, 0,             0, 4'h4, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h2, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h2, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h2, 0, 0, 0,             1, 4'h2, 4'h0, 0, A1, W1));
        vt.push_back(mk(1, 4'h2, 0, 0, 0,             1, 4'h2, 4'h0, 0, A1, W1));
        vt.push_back(mk(0, 4'h2, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h2, 0, 0, 0,             1, 4'h2, 4'h0, 0, A1, W1));
        vt.push_back(mk(0, 4'h0, 0, 0, 0,             0, 4'h2, 4'h0, 0, 0,  0));
        vt.push_back(mk(0, 4'h0, 0, 0, 0,             0, 4'h0, 4'h0, 0, 0,  0));

        foreach (vt[i]) begin
            @(negedge clk);
            rst = vt[i].rst; bus.rq_req = vt[i].req; bus.rq_we = vt[i].we;
            bus.mem_ack = vt[i].ack; bus.mem_rdata = vt[i].rdata;
            #1;
            $display("vec %0d: req=%h ack_in=%b mem_req=%b gnt=%h rq_ack=%h", i, vt[i].req,
                     vt[i].ack, bus.mem_req, bus.rq_gnt, bus.rq_ack);
            chk($sformatf("v%0d mem_req", i), 64'(bus.mem_req), 64'(vt[i].x_mreq));
            chk($sformatf("v%0d rq_gnt", i),  64'(bus.rq_gnt),  64'(vt[i].x_gnt));
            chk($sformatf("v%0d rq_ack", i),  64'(bus.rq_ack),  64'(vt[i].x_ack));
            if (vt[i].x_mreq) begin
                chk($sformatf("v%0d mem_we", i),    64'(bus.mem_we),    64'(vt[i].x_we));
                chk($sformatf("v%0d mem_addr", i),  64'(bus.mem_addr),  64'(vt[i].x_addr));
                chk($sformatf("v%0d mem_wdata", i), 64'(bus.mem_wdata), 64'(vt[i].x_wdata));
            end
            if (vt[i].x_ack != 0)
                chk($sformatf("v%0d rq_rdata", i), 64'(bus.rq_rdata), 64'(vt[i].rdata));
        end
        rst = 1'b0;

        // burst bound: req1 wants 10 words, req3 one word; expect 4 / 1 / 6 split
        do_reset();
        words_left = '{0, 10, 0, 1};
        done1 = 0; ack_plan = 1'b0; cyc = 0;
        while ((words_left[1] + words_left[3]) > 0 && cyc < 300) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) bus.rq_req[i] = (words_left[i] > 0);
            addr_tb[1] = 17'h0_0200 + 17'(done1);
            bus.mem_ack = ack_plan;
            bus.mem_rdata = 32'hB000_0000 + 32'(cyc);
            #1;
            if (bus.rq_ack != 0) begin
                owner = 0;
                for (int i = 0; i < NREQ; i++) if (bus.rq_ack[i]) owner = i;
                $display("burst ack: owner=%0d addr=%h", owner, bus.mem_addr);
                chk("burst ack onehot", 64'($countones(bus.rq_ack)), 64'd1);
                if (owner == 1) begin
                    chk($sformatf("burst req1 word%0d addr", done1), 64'(bus.mem_addr),
                        64'(17'h0_0200 + 17'(done1)));
                    done1++;
                end
                order.push_back(owner);
                if (words_left[owner] > 0) words_left[owner]--;
            end
            ack_plan = bus.mem_req && !bus.mem_ack;
            cyc++;
        end
        chk("burst finished in budget", 64'(cyc < 300), 64'd1);
        chk("burst ack count", 64'(order.size()), 64'd11);
        for (int k = 0; k < 11; k++)
            if (k < order.size())
                chk($sformatf("burst order%0d", k), 64'(order[k]), 64'(exp_order[k]));
        addr_tb[1] = A1;

        // random-ack soak: mem_req must hold while owner still wants the word
        do_reset();
        total_words = 0; total_acks = 0;
        for (int i = 0; i < NREQ; i++) begin
            words_left[i] = int'($urandom_range(1, 8));
            total_words += words_left[i];
        end
        ack_plan = 1'b0; prev_mreq = 1'b0; prev_ack = 1'b0; cyc = 0;
        while (total_acks < total_words && cyc < 3000) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) bus.rq_req[i] = (words_left[i] > 0);
            bus.mem_ack = ack_plan;
            bus.mem_rdata = $urandom;
            #1;
            if (prev_mreq && !prev_ack)
                chk($sformatf("soak hold c%0d", cyc), 64'(bus.mem_req), 64'd1);
            if (bus.rq_ack != 0) begin
                chk($sformatf("soak ack=gnt c%0d", cyc), 64'(bus.rq_ack), 64'(bus.rq_gnt));
                for (int i = 0; i < NREQ; i++)
                    if (bus.rq_ack[i] && words_left[i] > 0) words_left[i]--;
                total_acks++;
            end
            prev_mreq = bus.mem_req;
            prev_ack  = (bus.rq_ack != 0);
            ack_plan  = bus.mem_req && ($urandom_range(0, 2) != 0);
            cyc++;
        end
        $display("soak: %0d words, %0d acks, %0d cycles", total_words, total_acks, cyc);
        chk("soak all words acked", 64'(total_acks), 64'(total_words));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
